// File: rtl/osd_w_reenc_scorer.sv
// Sequential OSD re-encoder/scorer: walks every MRB test pattern of weight <= order,
// one per clock, re-encodes through P and keeps the minimum-discrepancy codeword.
module osd_w_reenc_scorer #(
  parameter int N         = 64,
  parameter int K         = 32,
  parameter int V_WIDTH   = 6,
  parameter int MAX_ORDER = 3,
  parameter int SCORE_W   = V_WIDTH + $clog2(N + 1),
  parameter int CNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid,
  input  logic [1:0]             order,
  input  logic [N-1:0]           hd_flat,
  input  logic [N*V_WIDTH-1:0]   mag_flat,
  input  logic [K*(N-K)-1:0]     P_flat,
  output logic                   busy,
  output logic                   valid_out,
  output logic [K-1:0]           best_info,
  output logic [N-1:0]           best_codeword,
  output logic [SCORE_W-1:0]     best_score,
  output logic [CNT_W-1:0]       best_index,
  output logic [CNT_W-1:0]       cand_count
);

  localparam int M  = N - K;
  localparam int IW = $clog2(K) + 1;
  localparam logic [IW-1:0] I_LAST  = IW'(K - 1);
  localparam logic [IW-1:0] I_LAST2 = IW'(K - 2);
  localparam logic [IW-1:0] I_LAST3 = IW'(K - 3);
  localparam bit W2_EMPTY = (K < 2);
  localparam bit W3_EMPTY = (K < 3);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q;
  logic [N-1:0]         hd_q;
  logic [N*V_WIDTH-1:0] mag_q;
  logic [K*M-1:0]       p_q;
  logic [1:0]           ord_q;
  logic [1:0]           w_q;
  logic [IW-1:0]        i_q, j_q, k_q;
  logic [CNT_W-1:0]     idx_q;
  logic                 busy_q, vout_q;
  logic [K-1:0]         best_info_q;
  logic [N-1:0]         best_cw_q;
  logic [SCORE_W-1:0]   best_score_q;
  logic [CNT_W-1:0]     best_index_q, cand_count_q;

  logic [1:0]           w_d;
  logic [IW-1:0]        i_d, j_d, k_d;
  logic                 tuple_end, cand_last;
  logic [K-1:0]         cand_e, cand_u;
  logic [M-1:0]         cand_par;
  logic [N-1:0]         cand_cw;
  logic [SCORE_W-1:0]   cand_d;
  logic [1:0]           ord_clamped;
  logic [V_WIDTH-1:0]   mag_a [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_mag
    assign mag_a[gi] = mag_q[gi*V_WIDTH +: V_WIDTH];
  end

  assign ord_clamped = (order > 2'(MAX_ORDER)) ? 2'(MAX_ORDER) : order;

  // Error pattern decoded from the current (weight, i, j, k) tuple.
  always_comb begin
    cand_e = '0;
    for (int b = 0; b < K; b++) begin
      if (w_q >= 2'd1 && i_q == IW'(b)) cand_e[b] = 1'b1;
      if (w_q >= 2'd2 && j_q == IW'(b)) cand_e[b] = 1'b1;
      if (w_q == 2'd3 && k_q == IW'(b)) cand_e[b] = 1'b1;
    end
  end

  assign cand_u = hd_q[K-1:0] ^ cand_e;

  always_comb begin
    cand_par = '0;
    for (int r = 0; r < K; r++) begin
      if (cand_u[r]) cand_par = cand_par ^ p_q[r*M +: M];
    end
  end

  assign cand_cw = {cand_par, cand_u};

  always_comb begin
    cand_d = '0;
    for (int n = 0; n < N; n++) begin
      if (cand_cw[n] != hd_q[n]) cand_d = cand_d + SCORE_W'(mag_a[n]);
    end
  end

  // Lexicographic successor of the current tuple; tuple_end flags the last tuple of a weight.
  always_comb begin
    w_d       = w_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    tuple_end = 1'b0;
    case (w_q)
      2'd0: tuple_end = 1'b1;
      2'd1: begin
        if (i_q != I_LAST) i_d = i_q + IW'(1);
        else               tuple_end = 1'b1;
      end
      2'd2: begin
        if (j_q != I_LAST) begin
          j_d = j_q + IW'(1);
        end else if (i_q != I_LAST2) begin
          i_d = i_q + IW'(1);
          j_d = i_q + IW'(2);
        end else begin
          tuple_end = 1'b1;
        end
      end
      default: begin
        if (k_q != I_LAST) begin
          k_d = k_q + IW'(1);
        end else if (j_q != I_LAST2) begin
          j_d = j_q + IW'(1);
          k_d = j_q + IW'(2);
        end else if (i_q != I_LAST3) begin
          i_d = i_q + IW'(1);
          j_d = i_q + IW'(2);
          k_d = i_q + IW'(3);
        end else begin
          tuple_end = 1'b1;
        end
      end
    endcase
    if (tuple_end) begin
      w_d = w_q + 2'd1;
      i_d = IW'(0);
      j_d = IW'(1);
      k_d = IW'(2);
    end
  end

  // Run ends at the requested weight, or earlier when the next weight has no tuples.
  assign cand_last = tuple_end &&
                     ((w_q == ord_q) ||
                      (w_q == 2'd1 && W2_EMPTY) ||
                      (w_q == 2'd2 && W3_EMPTY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hd_q         <= '0;
      mag_q        <= '0;
      p_q          <= '0;
      ord_q        <= '0;
      w_q          <= '0;
      i_q          <= '0;
      j_q          <= '0;
      k_q          <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      vout_q       <= 1'b0;
      best_info_q  <= '0;
      best_cw_q    <= '0;
      best_score_q <= '0;
      best_index_q <= '0;
      cand_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid) begin
            hd_q         <= hd_flat;
            mag_q        <= mag_flat;
            p_q          <= P_flat;
            ord_q        <= ord_clamped;
            w_q          <= 2'd0;
            i_q          <= IW'(0);
            j_q          <= IW'(1);
            k_q          <= IW'(2);
            idx_q        <= '0;
            best_score_q <= '1;
            busy_q       <= 1'b1;
            state_q      <= S_RUN;
          end
        end
        S_RUN: begin
          // Strict compare: on a tie the earlier enumeration index is kept.
          if (cand_d < best_score_q) begin
            best_info_q  <= cand_u;
            best_cw_q    <= cand_cw;
            best_score_q <= cand_d;
            best_index_q <= idx_q;
          end
          idx_q <= idx_q + CNT_W'(1);
          w_q   <= w_d;
          i_q   <= i_d;
          j_q   <= j_d;
          k_q   <= k_d;
          if (cand_last) begin
            vout_q       <= 1'b1;
            busy_q       <= 1'b0;
            cand_count_q <= idx_q + CNT_W'(1);
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          vout_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign valid_out     = vout_q;
  assign best_info     = best_info_q;
  assign best_codeword = best_cw_q;
  assign best_score    = best_score_q;
  assign best_index    = best_index_q;
  assign cand_count    = cand_count_q;

endmodule

// File: tb/tb_osd_w_reenc_scorer.sv
// Bench for osd_w_reenc_scorer: a small (8,4) and a full (64,32) instance, checked against
// a pattern-enumerating reference decoder.
module tb_osd_w_reenc_scorer;

  localparam int SN = 8, SK = 4, LN = 64, LK = 32, VW = 6;
  localparam int SSW = VW + $clog2(SN + 1);
  localparam int LSW = VW + $clog2(LN + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              s_valid, s_busy, s_vout;
  logic [1:0]        s_order;
  logic [SN-1:0]     s_hd, s_cw;
  logic [SN*VW-1:0]  s_mag;
  logic [SK*(SN-SK)-1:0] s_P;
  logic [SK-1:0]     s_info;
  logic [SSW-1:0]    s_score;
  logic [31:0]       s_index, s_count;

  logic              l_valid, l_busy, l_vout;
  logic [1:0]        l_order;
  logic [LN-1:0]     l_hd, l_cw;
  logic [LN*VW-1:0]  l_mag;
  logic [LK*(LN-LK)-1:0] l_P;
  logic [LK-1:0]     l_info;
  logic [LSW-1:0]    l_score;
  logic [31:0]       l_index, l_count;

  osd_w_reenc_scorer #(.N(SN), .K(SK), .V_WIDTH(VW), .MAX_ORDER(3)) dut_s (
    .clk(clk), .rst(rst), .valid(s_valid), .order(s_order),
    .hd_flat(s_hd), .mag_flat(s_mag), .P_flat(s_P),
    .busy(s_busy), .valid_out(s_vout), .best_info(s_info), .best_codeword(s_cw),
    .best_score(s_score), .best_index(s_index), .cand_count(s_count)
  );

  osd_w_reenc_scorer #(.N(LN), .K(LK), .V_WIDTH(VW), .MAX_ORDER(3)) dut_l (
    .clk(clk), .rst(rst), .valid(l_valid), .order(l_order),
    .hd_flat(l_hd), .mag_flat(l_mag), .P_flat(l_P),
    .busy(l_busy), .valid_out(l_vout), .best_info(l_info), .best_codeword(l_cw),
    .best_score(l_score), .best_index(l_index), .cand_count(l_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decoder state
  int          m_n, m_k;
  logic [63:0] m_hd;
  int          m_mag [64];
  logic [31:0] m_p [32];
  logic [63:0] r_cw;
  logic [31:0] r_info;
  longint      r_score, r_index, r_count;

  function automatic logic [63:0] encode(input logic [31:0] u);
    logic [31:0] par;
    logic [63:0] cw;
    par = '0;
    cw  = '0;
    for (int i = 0; i < m_k; i++) if (u[i]) par = par ^ m_p[i];
    for (int i = 0; i < m_k; i++) cw[i] = u[i];
    for (int j = 0; j < m_n - m_k; j++) cw[m_k + j] = par[j];
    return cw;
  endfunction

  task automatic consider(input logic [31:0] e);
    logic [31:0] u, mask;
    logic [63:0] cw;
    longint d;
    mask = (m_k == 32) ? 32'hFFFF_FFFF : ((32'd1 << m_k) - 32'd1);
    u  = (m_hd[31:0] ^ e) & mask;
    cw = encode(u);
    d  = 0;
    for (int n = 0; n < m_n; n++) if (cw[n] != m_hd[n]) d += longint'(m_mag[n]);
    if (d < r_score) begin
      r_score = d;
      r_info  = u;
      r_cw    = cw;
      r_index = r_count;
    end
    r_count++;
  endtask

  task automatic ref_run(input int ord);
    int o;
    o = (ord > 3) ? 3 : ord;
    r_score = 64'sh7FFF_FFFF_FFFF_FFFF;
    r_count = 0;
    r_index = 0;
    consider(32'd0);
    if (o >= 1) for (int i = 0; i < m_k; i++) consider(32'd1 << i);
    if (o >= 2)
      for (int i = 0; i < m_k; i++)
        for (int j = i + 1; j < m_k; j++) consider((32'd1 << i) | (32'd1 << j));
    if (o >= 3)
      for (int i = 0; i < m_k; i++)
        for (int j = i + 1; j < m_k; j++)
          for (int k = j + 1; k < m_k; k++)
            consider((32'd1 << i) | (32'd1 << j) | (32'd1 << k));
  endtask

  task automatic load_small();
    m_n = SN; m_k = SK;
    m_hd = 64'(s_hd);
    for (int n = 0; n < 64; n++) m_mag[n] = (n < SN) ? int'(s_mag[n*VW +: VW]) : 0;
    for (int i = 0; i < 32; i++) m_p[i] = (i < SK) ? 32'(s_P[i*(SN-SK) +: (SN-SK)]) : 32'd0;
  endtask

  task automatic load_large();
    m_n = LN; m_k = LK;
    m_hd = l_hd;
    for (int n = 0; n < 64; n++) m_mag[n] = int'(l_mag[n*VW +: VW]);
    for (int i = 0; i < 32; i++) m_p[i] = l_P[i*32 +: 32];
  endtask

  // Called and returns at #1 after a rising edge.
  task automatic run_s(input string tag, input int ord);
    int cyc;
    load_small();
    ref_run(ord);
    s_order = 2'(ord);
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_hd  = 8'($urandom);
    s_mag = 48'({$urandom, $urandom});
    s_P   = 16'($urandom);
    s_order = 2'($urandom);
    check_val({tag, "_busy"}, 64'(s_busy), 64'd1);
    cyc = 0;
    while (!s_vout && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val({tag, "_latency"}, 64'(cyc), 64'(r_count));
    check_val({tag, "_count"}, 64'(s_count), 64'(r_count));
    check_val({tag, "_score"}, 64'(s_score), 64'(r_score));
    check_val({tag, "_index"}, 64'(s_index), 64'(r_index));
    check_val({tag, "_info"}, 64'(s_info), 64'(r_info));
    check_val({tag, "_cw"}, 64'(s_cw), r_cw);
    $display("run %s order=%0d count=%0d score=%0d index=%0d info=%0h", tag, ord,
             s_count, s_score, s_index, s_info);
    @(posedge clk); #1;
    check_val({tag, "_pulse"}, 64'({s_vout, s_busy}), 64'd0);
  endtask

  task automatic run_l(input string tag, input int ord);
    int cyc;
    load_large();
    ref_run(ord);
    l_order = 2'(ord);
    l_valid = 1'b1;
    @(posedge clk); #1;
    l_valid = 1'b0;
    for (int q = 0; q < 32; q++) l_P[q*32 +: 32] = $urandom;
    l_hd = {$urandom, $urandom};
    cyc = 0;
    while (!l_vout && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val({tag, "_latency"}, 64'(cyc), 64'(r_count));
    check_val({tag, "_count"}, 64'(l_count), 64'(r_count));
    check_val({tag, "_score"}, 64'(l_score), 64'(r_score));
    check_val({tag, "_index"}, 64'(l_index), 64'(r_index));
    check_val({tag, "_info"}, 64'(l_info), 64'(r_info));
    check_val({tag, "_cw"}, l_cw, r_cw);
    $display("run %s order=%0d count=%0d score=%0d index=%0d", tag, ord,
             l_count, l_score, l_index);
    @(posedge clk); #1;
  endtask

  task automatic set_t2();
    s_P   = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    s_mag = {6'd5, 6'd5, 6'd5, 6'd5, 6'd1, 6'd6, 6'd7, 6'd8};
    s_hd  = 8'b0000_1000;
  endtask

  task automatic rand_large();
    for (int q = 0; q < 32; q++) l_P[q*32 +: 32] = $urandom;
    for (int q = 0; q < 12; q++) l_mag[q*32 +: 32] = $urandom;
    l_hd = {$urandom, $urandom};
  endtask

  int  cyc;
  bit  seen;

  initial begin
    s_valid = 0; s_order = 0; s_hd = 0; s_mag = 0; s_P = 0;
    l_valid = 0; l_order = 0; l_hd = 0; l_mag = 0; l_P = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_s_score", 64'(s_score), 64'd0);
    check_val("rst_s_ctl", 64'({s_busy, s_vout}), 64'd0);
    check_val("rst_s_count", 64'(s_count), 64'd0);
    check_val("rst_l_score", 64'(l_score), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: identity P, zero hard decisions
    s_P   = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    s_mag = {8{6'd5}};
    s_hd  = 8'd0;
    run_s("t1", 2);
    check_val("t1_spec_score", 64'(s_score), 64'd0);
    check_val("t1_spec_count", 64'(s_count), 64'd11);

    // T2
    set_t2();
    run_s("t2", 2);
    check_val("t2_spec_score", 64'(s_score), 64'd1);
    check_val("t2_spec_index", 64'(s_index), 64'd4);
    check_val("t2_spec_info", 64'(s_info), 64'd0);

    // T3: order sweep
    for (int o = 0; o < 4; o++) begin
      set_t2();
      run_s($sformatf("t3_o%0d", o), o);
      check_val($sformatf("t3_o%0d_spec_count", o), 64'(s_count), 64'((o == 0) ? 1 : (o == 1) ? 5 : (o == 2) ? 11 : 15));
      if (o == 0) begin
        check_val("t3_o0_spec_info", 64'(s_info), 64'h8);
        check_val("t3_o0_spec_score", 64'(s_score), 64'd5);
      end
    end

    // T4: idx2 (e=0010) and idx7 (e=1001) both score 10, the minimum
    s_P   = {4'b1100, 4'b0000, 4'b1111, 4'b0011};
    s_hd  = 8'b1111_0000;
    s_mag = {6'd20, 6'd20, 6'd20, 6'd20, 6'd5, 6'd30, 6'd10, 6'd5};
    run_s("t4", 2);
    check_val("t4_spec_index", 64'(s_index), 64'd2);
    check_val("t4_spec_score", 64'(s_score), 64'd10);

    // T5: valid during busy and during the DONE cycle is ignored
    set_t2();
    load_small();
    ref_run(2);
    s_order = 2'd2;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    cyc = 0;
    repeat (3) begin @(posedge clk); #1; cyc++; end
    s_valid = 1'b1;
    @(posedge clk); #1;
    cyc++;
    s_valid = 1'b0;
    while (!s_vout && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    check_val("t5_latency", 64'(cyc), 64'(r_count));
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (s_busy || s_vout) seen = 1'b1;
    end
    check_val("t5_ignored", 64'(seen), 64'd0);
    check_val("t5_count", 64'(s_count), 64'd11);
    check_val("t5_index", 64'(s_index), 64'd4);
    check_val("t5_score", 64'(s_score), 64'd1);
    set_t2();
    run_s("t5_rerun", 2);

    // T6: reset mid-run
    set_t2();
    s_order = 2'd2;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("t6_ctl", 64'({s_busy, s_vout}), 64'd0);
    check_val("t6_score", 64'(s_score), 64'd0);
    check_val("t6_count", 64'(s_count), 64'd0);
    check_val("t6_index", 64'(s_index), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (s_vout || s_busy) seen = 1'b1;
    end
    check_val("t6_no_vout", 64'(seen), 64'd0);
    set_t2();
    run_s("t6_rerun", 2);
    check_val("t6_spec_index", 64'(s_index), 64'd4);

    // Random small runs with narrow magnitudes to provoke ties
    for (int t = 0; t < 12; t++) begin
      s_hd = 8'($urandom);
      s_P  = 16'($urandom);
      for (int n = 0; n < SN; n++) s_mag[n*VW +: VW] = 6'($urandom_range(0, 7));
      run_s($sformatf("rs%0d", t), int'($urandom_range(0, 3)));
    end

    // T7: full-size instance
    for (int t = 0; t < 3; t++) begin
      rand_large();
      run_l($sformatf("t7_%0d", t), 2);
      check_val($sformatf("t7_%0d_spec_count", t), 64'(l_count), 64'd529);
    end
    rand_large();
    run_l("t7_o1", 1);
    rand_large();
    run_l("t7_o3", 3);
    check_val("t7_o3_spec_count", 64'(l_count), 64'd5489);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
